mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
Two-master Wishbone B4 pipelined arbiter. It shares the single external memory bus between the instruction-fetch port (if) and the exm load/store port (ls). Sits between the core's fetch/exm Wishbone masters and the top-level bus. The grant is registered and held for a whole bus cycle, and is only released once every outstanding request has been acknowledged.

Parameters:
OUTST_W, 2, width of outstanding-request counter (max outstanding = 2^OUTST_W-1 = 3)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
if_wb_adr_i / if_wb_dat_i  in  32 / 32  fetch master address / write data
if_wb_we_i, if_wb_stb_i, if_wb_cyc_i  in  1  fetch master controls
if_wb_sel_i  in  4  fetch master byte select
if_wb_dat_o  out  32  read data to fetch
if_wb_ack_o, if_wb_stall_o  out  1  ack/stall to fetch
ls_wb_* (same nine signals as if_wb_*)  -  -  load/store master (exm)
wb_adr_o, wb_dat_o  out  32  bus address/write data
wb_we_o, wb_stb_o, wb_cyc_o  out  1  bus controls
wb_sel_o  out  4  bus byte select
wb_dat_i  in  32  bus read data
wb_ack_i, wb_stall_i  in  1  bus ack/stall
grant_o  out  2  one-hot owner {ls,if}; 00 = idle

Behaviour:
- Reset (rst_ni=0 at rising edge): state IDLE, grant_o=00, outstanding count=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0.
  - Both *_ack_o=0; both *_stall_o=1.
  - Reset mid-transfer aborts immediately. Late acks arriving while IDLE are dropped and never forwarded.
- States: IDLE, GNT_IF, GNT_LS. grant_o reflects the state; it is a register output.
- IDLE -> GNT_LS if ls_wb_cyc_i. Else IDLE -> GNT_IF if if_wb_cyc_i. With both requesting, ls wins (fixed priority, unless the optional feature is enabled).
- GNT_x release condition: x_wb_cyc_i=0 and outstanding=0.
  - On release, arbitration is re-evaluated in the same cycle, so a direct handover GNT_IF -> GNT_LS takes no idle bubble.
  - If no request is pending, go to IDLE.
- Latency: a request raised in cycle N while IDLE is granted at edge N+1. The bus sees stb from cycle N+1.
- Muxing (combinational from the grant register):
  - Owner's adr/dat/we/sel drive the bus; wb_cyc_o = owner cyc; wb_stb_o = owner stb.
  - Owner gets wb_dat_i, wb_ack_i, wb_stall_i.
  - Non-owner: ack_o=0, stall_o=1, dat_o=wb_dat_i (don't-care).
  - IDLE: bus outputs at reset values.
- Outstanding counter:
  - +1 on wb_stb_o & ~wb_stall_o.
  - -1 on wb_ack_i.
  - Both in the same cycle: unchanged.
- Counter full (=3):
  - Owner stall_o is forced to 1 and wb_stb_o is forced to 0 until an ack arrives.
  - Underflow (ack with count 0) is ignored; the counter saturates at 0.
- Owner drops cyc with count>0: grant is held. wb_cyc_o is held at 1 until count reaches 0, so pending acks are still forwarded to the owner.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN:
- Defined: a 1-bit last-owner register (reset = if) is added. On simultaneous requests, the master that did NOT own the most recently completed grant wins.
- Undefined: fixed ls priority. The register is absent.

Decomposition:
- ecap5_dproc_pkg gains the arb_state_t enum (IDLE, GNT_IF, GNT_LS) and the constants GNT_NONE/GNT_IF/GNT_LS (2'b00/01/10).
- One natural sub-module: mem_arb_outst_cnt (saturating up/down counter with full/empty flags).

Test Plan:
1. if_wb_cyc_i=stb=1, adr=0x100, bus stall=0 -> grant_o=01 next cycle, wb_adr_o=0x100. Ack 2 cycles later appears on if_wb_ack_o; ls_wb_stall_o=1 throughout.
2. if and ls both raise cyc in the same cycle from IDLE -> grant_o=10. With MEM_ARB_ROUND_ROBIN_EN and last owner ls -> grant_o=01.
3. GNT_IF, if drops cyc in the same cycle ls raises cyc, count=0 -> grant_o goes 01->10 with no 00 cycle between.
4. ls issues 4 reads with wb_stall_i=0 and no ack -> count reaches 3. The 4th stb is blocked (wb_stb_o=0, ls_wb_stall_o=1) until the first ack, then issued.
5. ls drops cyc with 2 outstanding -> wb_cyc_o stays 1 and grant_o=10 until the second ack, then grant_o=00.
6. rst_ni=0 for one cycle during GNT_LS with 2 outstanding -> next cycle grant_o=00, wb_cyc_o=0. A subsequent wb_ack_i=1 is not seen on either *_ack_o.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// MEM_ARB_ROUND_ROBIN_EN (optional) swaps fixed ls priority for round-robin tie-breaking.
package mem_arb_pkg;

  localparam int WB_ADR_W        = 32;
  localparam int WB_DAT_W        = 32;
  localparam int WB_SEL_W        = 4;
  localparam int DEFAULT_OUTST_W = 2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_LS   = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_IF,
    ARB_GNT_LS
  } arb_state_t;

  function automatic logic [1:0] state_grant(input arb_state_t s);
    case (s)
      ARB_GNT_IF: return GNT_IF;
      ARB_GNT_LS: return GNT_LS;
      default:    return GNT_NONE;
    endcase
  endfunction

  // ls wins a tie unless if_first says the fetch port is owed the bus
  function automatic arb_state_t arb_pick(input logic if_req, input logic ls_req,
                                          input logic if_first);
    if (ls_req && !(if_first && if_req)) return ARB_GNT_LS;
    else if (if_req)                     return ARB_GNT_IF;
    else                                 return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Wishbone B4 pipelined link; master drives the request side, slave answers.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic [WB_SEL_W-1:0] sel;
  logic                we;
  logic                stb;
  logic                cyc;
  logic                ack;
  logic                stall;

  modport master (
    output adr, dat_w, sel, we, stb, cyc,
    input  dat_r, ack, stall
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc,
    output dat_r, ack, stall
  );

endinterface

// File: rtl/mem_arb_outst_cnt.sv
// Saturating up/down counter of bus requests issued but not yet acknowledged.
module mem_arb_outst_cnt #(
  parameter int W = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && r_count != CNT_MAX) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/mem_arb.sv
// Two-master Wishbone B4 pipelined arbiter (fetch + load/store onto one bus).
// Define MEM_ARB_ROUND_ROBIN_EN to break ties against the most recent owner.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int OUTST_W = DEFAULT_OUTST_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  mem_arb_if.slave   if_wb,
  mem_arb_if.slave   ls_wb,
  mem_arb_if.master  wb,
  output logic [1:0] grant_o
);

  arb_state_t r_state;
  logic [1:0] r_grant;
  arb_state_t w_pick;
  logic       w_if_first;
  logic       w_own_if;
  logic       w_own_ls;
  logic       w_owner_cyc;
  logic       w_owner_stb;
  logic       w_full;
  logic       w_empty;
  logic       w_inc;
  logic       w_dec;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_ls;
  assign w_if_first = r_last_ls;
`else
  assign w_if_first = 1'b0;
`endif

  assign w_pick   = arb_pick(if_wb.cyc, ls_wb.cyc, w_if_first);
  assign w_own_if = (r_grant == GNT_IF);
  assign w_own_ls = (r_grant == GNT_LS);
  assign grant_o  = r_grant;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_grant <= GNT_NONE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_ls <= 1'b0;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_state <= w_pick;
          r_grant <= state_grant(w_pick);
        end
        ARB_GNT_IF: begin
          // Re-arbitrate on release so a waiting ls takes over without an idle cycle
          if (!if_wb.cyc && w_empty) begin
            r_state <= w_pick;
            r_grant <= state_grant(w_pick);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_ls <= 1'b0;
`endif
          end
        end
        ARB_GNT_LS: begin
          if (!ls_wb.cyc && w_empty) begin
            r_state <= w_pick;
            r_grant <= state_grant(w_pick);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_ls <= 1'b1;
`endif
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= GNT_NONE;
        end
      endcase
    end
  end

  always_comb begin
    wb.adr      = '0;
    wb.dat_w    = '0;
    wb.sel      = '0;
    wb.we       = 1'b0;
    w_owner_cyc = 1'b0;
    w_owner_stb = 1'b0;
    if (w_own_if) begin
      wb.adr      = if_wb.adr;
      wb.dat_w    = if_wb.dat_w;
      wb.sel      = if_wb.sel;
      wb.we       = if_wb.we;
      w_owner_cyc = if_wb.cyc;
      w_owner_stb = if_wb.stb;
    end else if (w_own_ls) begin
      wb.adr      = ls_wb.adr;
      wb.dat_w    = ls_wb.dat_w;
      wb.sel      = ls_wb.sel;
      wb.we       = ls_wb.we;
      w_owner_cyc = ls_wb.cyc;
      w_owner_stb = ls_wb.stb;
    end
  end

  // cyc stays up after the owner lets go so in-flight acks still land
  assign wb.cyc = w_owner_cyc | ((r_grant != GNT_NONE) & ~w_empty);
  assign wb.stb = w_owner_stb & ~w_full;

  assign if_wb.dat_r = wb.dat_r;
  assign if_wb.ack   = w_own_if & wb.ack;
  assign if_wb.stall = ~w_own_if | wb.stall | w_full;

  assign ls_wb.dat_r = wb.dat_r;
  assign ls_wb.ack   = w_own_ls & wb.ack;
  assign ls_wb.stall = ~w_own_ls | wb.stall | w_full;

  assign w_inc = wb.stb & ~wb.stall;
  assign w_dec = wb.ack;

  mem_arb_outst_cnt #(
    .W (OUTST_W)
  ) u_outst_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb: reset, grant latency, priority, handover,
// outstanding limit, held cycle after cyc drop, and reset mid-transfer.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] grant_o;
  int         total  = 0;
  int         bad    = 0;

  always #5 clk_i = ~clk_i;

  mem_arb_if if_bus ();
  mem_arb_if ls_bus ();
  mem_arb_if mem_bus ();

  mem_arb #(
    .OUTST_W (2)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .if_wb   (if_bus),
    .ls_wb   (ls_bus),
    .wb      (mem_bus),
    .grant_o (grant_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_all();
    if_bus.adr = '0; if_bus.dat_w = '0; if_bus.sel = '0; if_bus.we = 1'b0;
    if_bus.stb = 1'b0; if_bus.cyc = 1'b0;
    ls_bus.adr = '0; ls_bus.dat_w = '0; ls_bus.sel = '0; ls_bus.we = 1'b0;
    ls_bus.stb = 1'b0; ls_bus.cyc = 1'b0;
    mem_bus.dat_r = '0; mem_bus.ack = 1'b0; mem_bus.stall = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_all();
    if_bus.adr = 32'hDEAD_BEEF; if_bus.sel = 4'hF; if_bus.we = 1'b1;
    repeat (2) next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL rst_grant got=%b want=00", grant_o); end
    total++; if (mem_bus.cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", mem_bus.cyc); end
    total++; if (mem_bus.stb !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=0", mem_bus.stb); end
    total++; if (mem_bus.we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_bus.we); end
    total++; if (mem_bus.adr !== 32'h0) begin bad++; $display("FAIL rst_adr got=%h want=0", mem_bus.adr); end
    total++; if (mem_bus.sel !== 4'h0) begin bad++; $display("FAIL rst_sel got=%h want=0", mem_bus.sel); end
    total++; if (if_bus.ack !== 1'b0 || ls_bus.ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b%b want=00", ls_bus.ack, if_bus.ack); end
    total++; if (if_bus.stall !== 1'b1 || ls_bus.stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b%b want=11", ls_bus.stall, if_bus.stall); end
    next_cycle();
    rst_ni = 1'b1;
    idle_all();
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL rst_idle_grant got=%b want=00", grant_o); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    next_cycle();
    if_bus.cyc = 1'b1; if_bus.stb = 1'b1; if_bus.adr = 32'h100; if_bus.sel = 4'hF;
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t1_latency got=%b want=00", grant_o); end
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_IF) begin bad++; $display("FAIL t1_grant got=%b want=01", grant_o); end
    total++; if (mem_bus.adr !== 32'h100) begin bad++; $display("FAIL t1_adr got=%h want=100", mem_bus.adr); end
    total++; if (mem_bus.stb !== 1'b1 || mem_bus.cyc !== 1'b1) begin bad++; $display("FAIL t1_stbcyc got=%b%b want=11", mem_bus.stb, mem_bus.cyc); end
    total++; if (if_bus.stall !== 1'b0) begin bad++; $display("FAIL t1_if_stall got=%b want=0", if_bus.stall); end
    next_cycle();
    if_bus.stb = 1'b0;
    #1;
    total++; if (ls_bus.stall !== 1'b1) begin bad++; $display("FAIL t1_ls_stall got=%b want=1", ls_bus.stall); end
    next_cycle();
    mem_bus.ack = 1'b1; mem_bus.dat_r = 32'hCAFE_F00D;
    #1;
    total++; if (if_bus.ack !== 1'b1) begin bad++; $display("FAIL t1_if_ack got=%b want=1", if_bus.ack); end
    total++; if (if_bus.dat_r !== 32'hCAFE_F00D) begin bad++; $display("FAIL t1_if_dat got=%h want=cafef00d", if_bus.dat_r); end
    total++; if (ls_bus.ack !== 1'b0 || ls_bus.stall !== 1'b1) begin bad++; $display("FAIL t1_ls_side got=ack%b stall%b want=ack0 stall1", ls_bus.ack, ls_bus.stall); end
    next_cycle();
    mem_bus.ack = 1'b0; if_bus.cyc = 1'b0;
    #1;
    total++; if (grant_o !== GNT_IF) begin bad++; $display("FAIL t1_hold got=%b want=01", grant_o); end
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t1_release got=%b want=00", grant_o); end
    $display("test_single_read done");
  endtask

  task automatic test_priority();
    next_cycle();
    if_bus.cyc = 1'b1; ls_bus.cyc = 1'b1;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_LS) begin bad++; $display("FAIL t2_tie got=%b want=10", grant_o); end
    total++; if (if_bus.stall !== 1'b1 || ls_bus.stall !== 1'b0) begin bad++; $display("FAIL t2_stall got=ls%b if%b want=ls0 if1", ls_bus.stall, if_bus.stall); end
    ls_bus.cyc = 1'b0;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_IF) begin bad++; $display("FAIL t2_handover got=%b want=01", grant_o); end
    if_bus.cyc = 1'b0;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t2_idle got=%b want=00", grant_o); end
    $display("test_priority done");
  endtask

  task automatic test_handover();
    next_cycle();
    if_bus.cyc = 1'b1;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_IF) begin bad++; $display("FAIL t3_if got=%b want=01", grant_o); end
    if_bus.cyc = 1'b0; ls_bus.cyc = 1'b1;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_LS) begin bad++; $display("FAIL t3_no_bubble got=%b want=10", grant_o); end
    ls_bus.cyc = 1'b0;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t3_idle got=%b want=00", grant_o); end
    $display("test_handover done");
  endtask

  task automatic test_full();
    next_cycle();
    ls_bus.cyc = 1'b1; ls_bus.stb = 1'b1; ls_bus.adr = 32'h200; ls_bus.sel = 4'hF;
    repeat (4) next_cycle();
    #1;
    total++; if (mem_bus.stb !== 1'b0 || ls_bus.stall !== 1'b1) begin bad++; $display("FAIL t4_full got=stb%b stall%b want=stb0 stall1", mem_bus.stb, ls_bus.stall); end
    total++; if (mem_bus.cyc !== 1'b1) begin bad++; $display("FAIL t4_cyc got=%b want=1", mem_bus.cyc); end
    next_cycle();
    #1;
    total++; if (mem_bus.stb !== 1'b0) begin bad++; $display("FAIL t4_still_full got=%b want=0", mem_bus.stb); end
    next_cycle();
    mem_bus.ack = 1'b1;
    #1;
    total++; if (ls_bus.ack !== 1'b1 || mem_bus.stb !== 1'b0) begin bad++; $display("FAIL t4_ack got=ack%b stb%b want=ack1 stb0", ls_bus.ack, mem_bus.stb); end
    next_cycle();
    mem_bus.ack = 1'b0;
    #1;
    total++; if (mem_bus.stb !== 1'b1 || ls_bus.stall !== 1'b0) begin bad++; $display("FAIL t4_fourth got=stb%b stall%b want=stb1 stall0", mem_bus.stb, ls_bus.stall); end
    next_cycle();
    ls_bus.stb = 1'b0; mem_bus.ack = 1'b1;
    next_cycle();
    next_cycle();
    ls_bus.cyc = 1'b0;
    next_cycle();
    mem_bus.ack = 1'b0;
    #1;
    total++; if (grant_o !== GNT_LS) begin bad++; $display("FAIL t4_drain got=%b want=10", grant_o); end
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t4_idle got=%b want=00", grant_o); end
    $display("test_full done");
  endtask

  task automatic test_drop_cyc();
    next_cycle();
    ls_bus.cyc = 1'b1; ls_bus.stb = 1'b1; ls_bus.adr = 32'h300;
    next_cycle();
    next_cycle();
    next_cycle();
    ls_bus.cyc = 1'b0; ls_bus.stb = 1'b0;
    #1;
    total++; if (mem_bus.cyc !== 1'b1 || grant_o !== GNT_LS) begin bad++; $display("FAIL t5_hold got=cyc%b gnt%b want=cyc1 gnt10", mem_bus.cyc, grant_o); end
    total++; if (mem_bus.stb !== 1'b0) begin bad++; $display("FAIL t5_stb got=%b want=0", mem_bus.stb); end
    next_cycle();
    mem_bus.ack = 1'b1;
    #1;
    total++; if (ls_bus.ack !== 1'b1) begin bad++; $display("FAIL t5_ack1 got=%b want=1", ls_bus.ack); end
    next_cycle();
    mem_bus.ack = 1'b0;
    #1;
    total++; if (mem_bus.cyc !== 1'b1 || grant_o !== GNT_LS) begin bad++; $display("FAIL t5_one_left got=cyc%b gnt%b want=cyc1 gnt10", mem_bus.cyc, grant_o); end
    next_cycle();
    mem_bus.ack = 1'b1;
    #1;
    total++; if (ls_bus.ack !== 1'b1) begin bad++; $display("FAIL t5_ack2 got=%b want=1", ls_bus.ack); end
    next_cycle();
    mem_bus.ack = 1'b0;
    #1;
    total++; if (mem_bus.cyc !== 1'b0) begin bad++; $display("FAIL t5_cyc_drop got=%b want=0", mem_bus.cyc); end
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_NONE) begin bad++; $display("FAIL t5_idle got=%b want=00", grant_o); end
    $display("test_drop_cyc done");
  endtask

  task automatic test_reset_mid();
    next_cycle();
    ls_bus.cyc = 1'b1; ls_bus.stb = 1'b1; ls_bus.adr = 32'h400;
    next_cycle();
    next_cycle();
    next_cycle();
    ls_bus.stb = 1'b0; rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1; ls_bus.cyc = 1'b0; mem_bus.ack = 1'b1;
    #1;
    total++; if (grant_o !== GNT_NONE || mem_bus.cyc !== 1'b0) begin bad++; $display("FAIL t6_abort got=gnt%b cyc%b want=gnt00 cyc0", grant_o, mem_bus.cyc); end
    total++; if (ls_bus.ack !== 1'b0 || if_bus.ack !== 1'b0) begin bad++; $display("FAIL t6_late_ack got=ls%b if%b want=00", ls_bus.ack, if_bus.ack); end
    next_cycle();
    #1;
    total++; if (ls_bus.ack !== 1'b0 || if_bus.ack !== 1'b0 || grant_o !== GNT_NONE) begin bad++; $display("FAIL t6_idle_ack got=ls%b if%b gnt%b want=0 0 00", ls_bus.ack, if_bus.ack, grant_o); end
    next_cycle();
    mem_bus.ack = 1'b0; if_bus.cyc = 1'b1; if_bus.stb = 1'b1; if_bus.adr = 32'h500;
    next_cycle();
    #1;
    total++; if (grant_o !== GNT_IF || mem_bus.stb !== 1'b1 || mem_bus.adr !== 32'h500) begin bad++; $display("FAIL t6_resume got=gnt%b stb%b adr%h want=01 1 500", grant_o, mem_bus.stb, mem_bus.adr); end
    idle_all();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_handover();
    test_full();
    test_drop_cyc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
